reg_bus_sequencer: RTL and testbench

- Sequences and arbitrates transfers between a bank of 10-bit load/output-enable registers that share one tri-state data bus in the matrix-multiplication datapath.
- Requesters each ask for a source→destination register copy. A round-robin arbiter grants one request at a time.
- The block drives the one-hot output-enable and load strobes, so exactly one register drives the bus while the destination latches it.
- All strobes are glitch-free registered outputs, because each register gates its clock with its load line.

---
 rtl/reg_bus_sequencer.sv | 97 +++++++++
 tb/tb_reg_bus_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: round-robin sequencer driving one-hot OE/L strobes for registers sharing one tri-state bus.
// Optional BUS_TURNAROUND_EN adds a dead TURN cycle after every ACK.
module reg_bus_sequencer #(
  parameter int NREG = 8,
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREG)
) (
  input  logic                 Clk,
  input  logic                 MR,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IW-1:0]   src,
  input  logic [NREQ*IW-1:0]   dst,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [NREG-1:0]      OE,
  output logic [NREG-1:0]      L,
  output logic                 busy
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, DRIVE, XFER, ACK, TURN} state_t;
  state_t st, nst;
  logic [GW-1:0] rr, nrr, g, ng;
  logic [IW-1:0] s, ns, d, nd;
  logic bad, nbad, found;
  logic [NREG-1:0] n_oe, n_l;
  logic [NREQ-1:0] n_ack;
  logic n_err;
  int j;
  always_comb begin
    nst = st;
    nrr = rr;
    ng = g;
    ns = s;
    nd = d;
    nbad = bad;
    found = 1'b0;
    j = 0;
    case (st)
      IDLE: begin
        for (int k = 0; k < NREQ; k++) begin
          j = (int'(rr) + k) % NREQ;
          if (!found && req[j]) begin
            found = 1'b1;
            ng = GW'(j);
            ns = src[j*IW +: IW];
            nd = dst[j*IW +: IW];
          end
        end
        if (found) begin
          nrr = GW'((int'(ng) + 1) % NREQ);
          nbad = (ns == nd) || (int'(ns) >= NREG) || (int'(nd) >= NREG);
          nst = nbad ? ACK : DRIVE;
        end
      end
      DRIVE: nst = XFER;
`ifdef BUS_TURNAROUND_EN
      ACK: nst = TURN;
`else
      ACK: nst = IDLE;
`endif
      XFER: nst = ACK;
      default: nst = IDLE;
    endcase
    // Strobes are decoded from the next state so they leave a flop cleanly.
    n_oe = (nst == DRIVE || nst == XFER) ? NREG'(1) << ns : '0;
    n_l = (nst == XFER) ? NREG'(1) << nd : '0;
    n_ack = (nst == ACK) ? NREQ'(1) << ng : '0;
    n_err = (nst == ACK) && nbad;
  end
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      st <= IDLE;
      rr <= '0;
      g <= '0;
      s <= '0;
      d <= '0;
      bad <= 1'b0;
      OE <= '0;
      L <= '0;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= nst;
      rr <= nrr;
      g <= ng;
      s <= ns;
      d <= nd;
      bad <= nbad;
      OE <= n_oe;
      L <= n_l;
      ack <= n_ack;
      err <= n_err;
      busy <= nst != IDLE;
    end
  end
endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: directed bench with an ack scoreboard for reg_bus_sequencer.
module tb_reg_bus_sequencer;
`ifdef BUS_TURNAROUND_EN
  localparam int PER = 5, DEAD = 1;
`else
  localparam int PER = 4, DEAD = 0;
`endif
  logic Clk = 1'b0, MR = 1'b0;
  logic [3:0] req = '0;
  logic [11:0] src = '0, dst = '0;
  logic [3:0] ack;
  logic err, busy;
  logic [7:0] OE, L;
  logic req5 = 1'b0;
  logic [2:0] src5 = '0, dst5 = '0;
  logic ack5, err5, busy5;
  logic [4:0] OE5, L5;
  typedef struct {int g; logic e;} exp_t;
  exp_t sb[$];
  int ack_t[$];
  int n_chk = 0, n_err = 0, cyc_n = 0, dead_cnt = 0;

  reg_bus_sequencer dut (.Clk(Clk), .MR(MR), .req(req), .src(src), .dst(dst),
    .ack(ack), .err(err), .OE(OE), .L(L), .busy(busy));
  reg_bus_sequencer #(.NREG(5), .NREQ(1)) u5 (.Clk(Clk), .MR(MR), .req(req5), .src(src5),
    .dst(dst5), .ack(ack5), .err(err5), .OE(OE5), .L(L5), .busy(busy5));

  always #5 Clk = ~Clk;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    exp_t x;
    @(posedge Clk);
    #1;
    cyc_n++;
    chk("oe_onehot", 32'($countones(OE) <= 1), 1);
    chk("l_onehot", 32'($countones(L) <= 1), 1);
    if (busy && OE == 0 && L == 0 && ack == 0) dead_cnt++;
    if (ack != 0) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 0);
      else begin
        x = sb.pop_front();
        chk("ack", 32'(ack), 32'(1) << x.g);
        chk("err", 32'(err), 32'(x.e));
      end
      ack_t.push_back(cyc_n);
      req = req & ~ack;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) cyc();
    chk("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  task automatic set_rq(input int i, input int s, input int d);
    src[i*3 +: 3] = 3'(s);
    dst[i*3 +: 3] = 3'(d);
    req[i] = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_outs", 32'({ack, err, OE, L, busy}), 0);
    @(negedge Clk) MR = 1'b1;
    repeat (2) cyc();
    chk("idle_busy", 32'(busy), 0);
    // single transfer 2 -> 5
    set_rq(0, 2, 5);
    sb.push_back('{0, 1'b0});
    cyc();
    chk("t1_c1_oe", 32'(OE), 32'h04);
    chk("t1_c1_l", 32'(L), 0);
    chk("t1_c1_busy", 32'(busy), 1);
    cyc();
    chk("t1_c2_oe", 32'(OE), 32'h04);
    chk("t1_c2_l", 32'(L), 32'h20);
    cyc();
    chk("t1_c3_ack", 32'(ack), 1);
    chk("t1_c3_strobes", 32'({OE, L}), 0);
    chk("t1_ack_seen", ack_t.size(), 1);
    repeat (3) cyc();
    // bring rr_ptr back to 0
    set_rq(3, 0, 1);
    sb.push_back('{3, 1'b0});
    drain(20);
    repeat (3) cyc();
    // contention
    ack_t.delete();
    dead_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      set_rq(i, i, i + 4);
      sb.push_back('{i, 1'b0});
    end
    drain(40);
    repeat (3) cyc();
    chk("t2_dead", dead_cnt, 4 * DEAD);
    chk("t2_acks", ack_t.size(), 4);
    if (ack_t.size() == 4)
      for (int i = 1; i < 4; i++) chk("t2_spacing", ack_t[i] - ack_t[i-1], PER);
    // illegal requests
    set_rq(2, 3, 3);
    sb.push_back('{2, 1'b1});
    cyc();
    chk("t3_a_ack", 32'(ack), 32'h4);
    chk("t3_a_strobes", 32'({OE, L}), 0);
    repeat (2 + DEAD) cyc();
    set_rq(1, 6, 6);
    sb.push_back('{1, 1'b1});
    cyc();
    chk("t3_b_ack", 32'(ack), 32'h2);
    chk("t3_b_strobes", 32'({OE, L}), 0);
    repeat (2 + DEAD) cyc();
    req5 = 1'b1; src5 = 3'd1; dst5 = 3'd6;
    cyc();
    chk("t3_oor_ackerr", 32'({ack5, err5}), 2'b11);
    chk("t3_oor_strobes", 32'({OE5, L5}), 0);
    req5 = 1'b0;
    repeat (3) cyc();
    req5 = 1'b1; src5 = 3'd4; dst5 = 3'd0;
    cyc();
    chk("t3_n5_oe", 32'(OE5), 32'h10);
    cyc();
    chk("t3_n5_l", 32'(L5), 32'h01);
    cyc();
    chk("t3_n5_ackerr", 32'({ack5, err5}), 2'b10);
    req5 = 1'b0;
    repeat (3) cyc();
    // fairness wrap: grant 2 leaves rr_ptr at 3
    set_rq(2, 1, 0);
    sb.push_back('{2, 1'b0});
    drain(20);
    repeat (3) cyc();
    set_rq(0, 3, 4);
    set_rq(3, 5, 6);
    sb.push_back('{3, 1'b0});
    sb.push_back('{0, 1'b0});
    drain(30);
    repeat (3) cyc();
    // mid-op reset: rr_ptr is 1, so requester 2 is granted first
    set_rq(2, 1, 0);
    set_rq(3, 2, 7);
    cyc();
    chk("t5_drive_oe", 32'(OE), 32'h02);
    #2 MR = 1'b0;
    #1 chk("t5_async", 32'({ack, OE, L, busy}), 0);
    cyc();
    chk("t5_held", 32'({ack, OE, L, busy}), 0);
    @(negedge Clk) MR = 1'b1;
    sb.push_back('{2, 1'b0});
    sb.push_back('{3, 1'b0});
    drain(40);
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
